fetch_unit: RTL

- Parametrised instruction-fetch front end for the next-generation MIPS core. It replaces the single-cycle processor's implicit combinational PC/instruction-memory path.
- Generates sequential PCs starting from startPC and issues requests over a request/grant instruction-memory handshake with in-order, variable-latency responses.
- Buffers returned instructions and their PCs in a DEPTH-entry prefetch FIFO. Supports redirects (branch/jump/exception) with flush of stale in-flight responses.
- Sits between instruction memory and the decode stage.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/sync_fifo.sv | 84 ++++++++
 rtl/fetch_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
// Addresses are handled as MAX_ADDR_W-bit values inside helpers and cast back by the caller.
package fetch_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } fetch_state_t;

   localparam int PC_INC     = 4;
   localparam int MAX_ADDR_W = 64;

   // Instructions are word aligned: the two low address bits are always cleared.
   function automatic logic [MAX_ADDR_W-1:0] align_pc(input logic [MAX_ADDR_W-1:0] pc);
      return pc & ~MAX_ADDR_W'(3);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word, element count and single-cycle flush.
// Flush dominates push and pop in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [WIDTH-1:0]       din_i,
   output logic [WIDTH-1:0]       head_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d, rd_nxt;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             do_push, do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != FULL) || do_pop);
   assign rd_nxt  = rd_q + AW'(1);

   always_comb begin
      rd_d    = rd_q;
      wr_d    = wr_q;
      count_d = count_q;
      if (flush_i) begin
         rd_d    = '0;
         wr_d    = '0;
         count_d = '0;
      end else begin
         if (do_pop)  rd_d = rd_nxt;
         if (do_push) wr_d = wr_q + AW'(1);
         if (do_push && !do_pop)      count_d = count_q + CW'(1);
         else if (do_pop && !do_push) count_d = count_q - CW'(1);
      end
   end

   // The head register always mirrors the oldest live entry, so the consumer sees a flop output.
   always_comb begin
      head_d = head_q;
      if (flush_i) begin
         head_d = '0;
      end else if (do_pop) begin
         if (count_q == CW'(1)) begin
            if (do_push) head_d = din_i;
         end else begin
            head_d = mem_q[rd_nxt];
         end
      end else if (do_push && (count_q == '0)) begin
         head_d = din_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
         head_q  <= '0;
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
         head_q  <= head_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wr_q] <= din_i;
   end

   assign head_o  = head_q;
   assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequential PC generation, request/grant memory handshake,
// prefetch FIFO toward decode and redirect with discard of stale in-flight responses.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 4,
   parameter int INST_W = 32
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] startPC,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [INST_W-1:0] imem_rdata,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc,
   input  logic              inst_ready
);

   localparam int          CW      = $clog2(DEPTH) + 1;
   localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

   fetch_state_t state_q, state_d;

   logic [ADDR_W-1:0]        pc_q, pc_d;
   logic [ADDR_W-1:0]        rpc_q, rpc_d;
   logic [CW-1:0]            outst_q, outst_d;
   logic [CW-1:0]            discard_q, discard_d;
   logic [CW-1:0]            count;
   logic [CW:0]              inflight;
   logic [ADDR_W-1:0]        start_al, redir_al;
   logic                     gnt_fire, rv_fire, rv_drop, push, redir;
   logic [INST_W+ADDR_W-1:0] fifo_din, fifo_head;

   // ---------------- FSM: state register / next state / outputs ----------------
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) state_q <= INIT;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (state_q == INIT) state_d = RUN;
   end

   // Credit rule: buffered plus in-flight never exceeds DEPTH, so the FIFO cannot overflow.
   always_comb begin
      imem_req = 1'b0;
      if (state_q == RUN) imem_req = (inflight < CREDITS);
   end

   // ---------------- Datapath ----------------
   assign inflight  = {1'b0, count} + {1'b0, outst_q};
   assign imem_addr = pc_q;
   assign gnt_fire  = imem_req && imem_gnt;
   assign rv_fire   = imem_rvalid && (outst_q != '0);
   assign rv_drop   = rv_fire && (discard_q != '0);
   assign redir     = redirect && (state_q == RUN);
   assign push      = rv_fire && !rv_drop && !redir;
   assign start_al  = ADDR_W'(align_pc(MAX_ADDR_W'(startPC)));
   assign redir_al  = ADDR_W'(align_pc(MAX_ADDR_W'(redirect_pc)));

   assign outst_d = outst_q + CW'(gnt_fire) - CW'(rv_fire);

   always_comb begin
      pc_d = pc_q;
      if (state_q == INIT)  pc_d = start_al;
      else if (redir)       pc_d = redir_al;
      else if (gnt_fire)    pc_d = pc_q + ADDR_W'(PC_INC);
   end

   // Responses return in order and stale ones are dropped, so a running counter
   // reloaded on redirect names each accepted response.
   always_comb begin
      rpc_d = rpc_q;
      if (state_q == INIT)  rpc_d = start_al;
      else if (redir)       rpc_d = redir_al;
      else if (push)        rpc_d = rpc_q + ADDR_W'(PC_INC);
   end

   // After a redirect every response still owed by memory belongs to the old stream.
   always_comb begin
      discard_d = discard_q;
      if (redir)        discard_d = outst_d;
      else if (rv_drop) discard_d = discard_q - CW'(1);
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         pc_q      <= '0;
         rpc_q     <= '0;
         outst_q   <= '0;
         discard_q <= '0;
      end else begin
         pc_q      <= pc_d;
         rpc_q     <= rpc_d;
         outst_q   <= outst_d;
         discard_q <= discard_d;
      end
   end

   // ---------------- Prefetch FIFO ----------------
   assign fifo_din = {imem_rdata, rpc_q};

   sync_fifo #(
      .WIDTH (INST_W + ADDR_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_i   (Reset),
      .flush_i (redir),
      .push_i  (push),
      .pop_i   (inst_ready),
      .din_i   (fifo_din),
      .head_o  (fifo_head),
      .count_o (count)
   );

   assign {inst, inst_pc} = fifo_head;
   assign inst_valid      = (count != '0);

   a_rvalid_outst : assert property (@(posedge CLK) disable iff (Reset)
      imem_rvalid |-> (outst_q != '0))
      else $error("fetch_unit: imem_rvalid with no request outstanding");

endmodule
